// File: rtl/goertzel_block_sequencer.sv
// Block sequencer for a Goertzel detector: feeds one sample at a time through an
// external fixed-latency inner-loop component and keeps the two-tap recursion state.
module goertzel_block_sequencer #(
  parameter int D_W      = 16,
  parameter int N_W      = 8,
  parameter int LOOP_LAT = 3
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  input  logic [N_W-1:0] block_len,
  input  logic [D_W-1:0] coeff,
  input  logic [D_W-1:0] samp_data,
  input  logic           samp_valid,
  output logic           samp_ready,
  output logic [D_W-1:0] loop_coeff,
  output logic [D_W-1:0] loop_t1,
  output logic [D_W-1:0] loop_t2,
  output logic [D_W-1:0] loop_data,
  input  logic [D_W-1:0] loop_t1_out,
  output logic           busy,
  output logic           done,
  output logic [D_W-1:0] res_t1,
  output logic [D_W-1:0] res_t2
);

  localparam int              LAT_W    = (LOOP_LAT > 1) ? $clog2(LOOP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LOOP_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SAMPLE, WAIT_LOOP, FINISH} state_t;

  state_t         state, state_nxt;
  logic [D_W-1:0] coeff_q, t1, t2;
  logic [N_W-1:0] len_q, cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic           lat_hit, last_sample;

  assign lat_hit     = (lat_cnt == LAT_LAST);
  // One extra bit so a block of 2^N_W-1 samples compares without wrapping.
  assign last_sample = (({1'b0, cnt} + (N_W+1)'(1)) == {1'b0, len_q});

  always_ff @(posedge sys_clk) begin
    // NOTE: reset is sampled on the clock edge here, so it lives inside the
    // clocked block and needs no separate sensitivity entry.
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt  = state;
    samp_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (block_len == '0) ? FINISH : WAIT_SAMPLE;
      end
      WAIT_SAMPLE: begin
        samp_ready = 1'b1;
        if (samp_valid) state_nxt = WAIT_LOOP;
      end
      WAIT_LOOP: begin
        if (lat_hit) state_nxt = last_sample ? FINISH : WAIT_SAMPLE;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      coeff_q    <= '0;
      len_q      <= '0;
      t1         <= '0;
      t2         <= '0;
      cnt        <= '0;
      lat_cnt    <= '0;
      loop_coeff <= '0;
      loop_t1    <= '0;
      loop_t2    <= '0;
      loop_data  <= '0;
      res_t1     <= '0;
      res_t2     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          coeff_q <= coeff;
          len_q   <= block_len;
          t1      <= '0;
          t2      <= '0;
          cnt     <= '0;
          if (block_len == '0) begin
            res_t1 <= '0;
            res_t2 <= '0;
          end
        end
        WAIT_SAMPLE: if (samp_valid) begin
          loop_data  <= samp_data;
          loop_t1    <= t1;
          loop_t2    <= t2;
          loop_coeff <= coeff_q;
          lat_cnt    <= '0;
        end
        WAIT_LOOP: begin
          if (lat_hit) begin
            t2  <= t1;
            t1  <= loop_t1_out;
            cnt <= cnt + N_W'(1);
            if (last_sample) begin
              res_t1 <= loop_t1_out;
              res_t2 <= t1;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
